fs_mp_seq: RTL and testbench

//  Multi-precision subtract sequencer. Computes OP_A - OP_B - BORROW_IN on operands WIDTH*WORDS bits wide.

---
 rtl/fs_pkg.sv | 19 +
 rtl/fs_mp_seq_if.sv | 33 +++
 rtl/fs_Nb.sv | 20 ++
 rtl/fs_mp_seq.sv | 107 ++++++++++
 tb/tb_fs_mp_seq.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fs_pkg.sv
// Shared types for the multi-precision subtract sequencer.
// Holds the FSM encoding and the operand word-select helper.
package fs_pkg;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_DONE = 2'd2
  } fs_state_e;

  // Bit offset of word idx inside a packed operand.
  function automatic int unsigned word_lo(
    input int unsigned idx,
    input int unsigned width
  );
    return idx * width;
  endfunction

endpackage

// File: rtl/fs_mp_seq_if.sv
// Request/result handshake bundle of the subtract sequencer.
// master = requester/consumer side, slave = sequencer side.
interface fs_mp_seq_if #(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
);
  logic                   START_VALID;
  logic                   START_READY;
  logic [WIDTH*WORDS-1:0] OP_A;
  logic [WIDTH*WORDS-1:0] OP_B;
  logic                   BORROW_IN;
  logic                   ABORT;
  logic                   RES_VALID;
  logic                   RES_READY;
  logic [WIDTH*WORDS-1:0] RESULT;
  logic                   BORROW_OUT;
  logic                   ZERO;
  logic                   BUSY;

  modport master (
    output START_VALID, OP_A, OP_B, BORROW_IN,
    output ABORT, RES_READY,
    input  START_READY, RES_VALID, RESULT,
    input  BORROW_OUT, ZERO, BUSY
  );

  modport slave (
    input  START_VALID, OP_A, OP_B, BORROW_IN,
    input  ABORT, RES_READY,
    output START_READY, RES_VALID, RESULT,
    output BORROW_OUT, ZERO, BUSY
  );
endinterface

// File: rtl/fs_Nb.sv
// WIDTH-bit full subtractor slice: DIFF = IN0 - IN1 - BORROW_IN.
// BORROW_OUT is the sign bit of the one-bit-wider difference.
module fs_Nb #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] IN0,
  input  logic [WIDTH-1:0] IN1,
  input  logic             BORROW_IN,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW_OUT
);
  logic [WIDTH:0] full;

  assign full = {1'b0, IN0}
              - {1'b0, IN1}
              - {{WIDTH{1'b0}}, BORROW_IN};

  assign DIFF       = full[WIDTH-1:0];
  assign BORROW_OUT = full[WIDTH];
endmodule

// File: rtl/fs_mp_seq.sv
// Multi-precision subtract sequencer: one WIDTH-bit slice,
// one word per cycle, LS word first, borrow carried in brw_q.
module fs_mp_seq
  import fs_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) (
  input logic        CLK,
  input logic        RSTn,
  fs_mp_seq_if.slave bus
);
  localparam int N     = WIDTH * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LO_W  = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  fs_state_e        state_q;
  logic [IDX_W-1:0] idx_q;
  logic             brw_q;
  logic [N-1:0]     a_q, b_q;
  logic [N-1:0]     res_q, res_d;
  logic             bout_q, zero_q, vld_q;

  logic [LO_W-1:0]  lo;
  logic [WIDTH-1:0] a_w, b_w, diff;
  logic             sbor;

  assign lo  = LO_W'(word_lo(32'(idx_q), WIDTH));
  assign a_w = a_q[lo +: WIDTH];
  assign b_w = b_q[lo +: WIDTH];

  fs_Nb #(.WIDTH(WIDTH)) u_slice (
    .IN0        (a_w),
    .IN1        (b_w),
    .BORROW_IN  (brw_q),
    .DIFF       (diff),
    .BORROW_OUT (sbor)
  );

  always_comb begin
    res_d            = res_q;
    res_d[lo +: WIDTH] = diff;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= FS_IDLE;
      idx_q   <= '0;
      brw_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else if (bus.ABORT) begin
      state_q <= FS_IDLE;
      idx_q   <= '0;
      brw_q   <= 1'b0;
      res_q   <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      unique case (state_q)
        FS_IDLE: begin
          if (bus.START_VALID) begin
            a_q     <= bus.OP_A;
            b_q     <= bus.OP_B;
            brw_q   <= bus.BORROW_IN;
            idx_q   <= '0;
            state_q <= FS_RUN;
          end
        end
        FS_RUN: begin
          res_q <= res_d;
          brw_q <= sbor;
          if (idx_q == LAST) begin
            // all words are final on this edge
            bout_q  <= sbor;
            zero_q  <= (res_d == '0);
            vld_q   <= 1'b1;
            idx_q   <= '0;
            state_q <= FS_DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        FS_DONE: begin
          if (bus.RES_READY) begin
            vld_q   <= 1'b0;
            state_q <= FS_IDLE;
          end
        end
        default: state_q <= FS_IDLE;
      endcase
    end
  end

  assign bus.START_READY = (state_q == FS_IDLE);
  assign bus.BUSY        = (state_q != FS_IDLE);
  assign bus.RES_VALID   = vld_q;
  assign bus.RESULT      = res_q;
  assign bus.BORROW_OUT  = bout_q;
  assign bus.ZERO        = zero_q;
endmodule

// File: tb/tb_fs_mp_seq.sv
// Directed bench for fs_mp_seq at WIDTH=4, WORDS=4.
module tb_fs_mp_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fs_mp_seq_if #(.WIDTH(4), .WORDS(4)) bus ();

  fs_mp_seq #(.WIDTH(4), .WORDS(4)) dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .bus  (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        bin,
    output int          lat
  );
    bus.OP_A        = a;
    bus.OP_B        = b;
    bus.BORROW_IN   = bin;
    bus.START_VALID = 1'b1;
    tick();
    bus.START_VALID = 1'b0;
    lat = 0;
    while (bus.RES_VALID !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_op;
    bus.RES_READY = 1'b1;
    tick();
    bus.RES_READY = 1'b0;
  endtask

  task automatic test_reset;
    rst_n           = 1'b0;
    bus.START_VALID = 1'b0;
    bus.OP_A        = '0;
    bus.OP_B        = '0;
    bus.BORROW_IN   = 1'b0;
    bus.ABORT       = 1'b0;
    bus.RES_READY   = 1'b0;
    #2;
    tests++;
    if ({bus.RES_VALID, bus.BUSY, bus.ZERO,
         bus.BORROW_OUT, bus.RESULT} !== 20'h0) begin
      fails++;
      $display("FAIL reset_outs got %h want 0",
        {bus.RES_VALID, bus.BUSY, bus.ZERO,
         bus.BORROW_OUT, bus.RESULT});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if (bus.START_READY !== 1'b1) begin
      fails++;
      $display("FAIL reset_rdy got %b want 1",
        bus.START_READY);
    end
  endtask

  task automatic test_basic;
    int lat;
    run_op(16'h1234, 16'h0235, 1'b0, lat);
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL basic_lat got %0d want 4", lat);
    end
    tests++;
    if ({bus.RESULT, bus.BORROW_OUT, bus.ZERO}
        !== {16'h0FFF, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL basic_res got %h/%b/%b want 0fff/0/0",
        bus.RESULT, bus.BORROW_OUT, bus.ZERO);
    end
    finish_op();
    tests++;
    if ({bus.RES_VALID, bus.START_READY} !== 2'b01) begin
      fails++;
      $display("FAIL basic_ret got %b want 01",
        {bus.RES_VALID, bus.START_READY});
    end
  endtask

  task automatic test_borrow;
    int lat;
    run_op(16'h0000, 16'h0001, 1'b0, lat);
    tests++;
    if ({lat == 4, bus.RESULT, bus.BORROW_OUT, bus.ZERO}
        !== {1'b1, 16'hFFFF, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL borrow got lat%0d %h/%b/%b want 4 ffff/1/0",
        lat, bus.RESULT, bus.BORROW_OUT, bus.ZERO);
    end
    finish_op();
  endtask

  task automatic test_zero;
    int lat;
    run_op(16'h0010, 16'h000F, 1'b1, lat);
    tests++;
    if ({lat == 4, bus.RESULT, bus.BORROW_OUT, bus.ZERO}
        !== {1'b1, 16'h0000, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL zero got lat%0d %h/%b/%b want 4 0000/0/1",
        lat, bus.RESULT, bus.BORROW_OUT, bus.ZERO);
    end
    finish_op();
  endtask

  task automatic test_hold;
    int lat;
    run_op(16'hBEEF, 16'hBEEF, 1'b0, lat);
    bus.OP_A = 16'h0001;
    bus.OP_B = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      bus.START_VALID = 1'b1;
      tick();
      tests++;
      if ({bus.RES_VALID, bus.START_READY, bus.ZERO,
           bus.RESULT} !== {1'b1, 1'b0, 1'b1, 16'h0}) begin
        fails++;
        $display("FAIL hold%0d got %b%b%b %h want 101 0000",
          i, bus.RES_VALID, bus.START_READY, bus.ZERO,
          bus.RESULT);
      end
    end
    bus.START_VALID = 1'b0;
    finish_op();
    tick();
    tests++;
    if ({bus.BUSY, bus.RES_VALID, bus.RESULT}
        !== {2'b00, 16'h0}) begin
      fails++;
      $display("FAIL hold_ign got %b%b %h want 00 0000",
        bus.BUSY, bus.RES_VALID, bus.RESULT);
    end
  endtask

  task automatic test_abort;
    int lat;
    bus.OP_A        = 16'hFFFF;
    bus.OP_B        = 16'h0000;
    bus.BORROW_IN   = 1'b0;
    bus.START_VALID = 1'b1;
    tick();
    bus.START_VALID = 1'b0;
    tick();
    tick();
    tests++;
    if ({bus.BUSY, bus.RESULT} !== {1'b1, 16'h00FF}) begin
      fails++;
      $display("FAIL abort_pre got %b %h want 1 00ff",
        bus.BUSY, bus.RESULT);
    end
    bus.ABORT = 1'b1;
    tick();
    bus.ABORT = 1'b0;
    tests++;
    if ({bus.BUSY, bus.RES_VALID, bus.ZERO, bus.BORROW_OUT,
         bus.START_READY, bus.RESULT}
        !== {5'b00001, 16'h0}) begin
      fails++;
      $display("FAIL abort_run got %b%b%b%b%b %h want 00001 0",
        bus.BUSY, bus.RES_VALID, bus.ZERO, bus.BORROW_OUT,
        bus.START_READY, bus.RESULT);
    end
    run_op(16'h0005, 16'h0003, 1'b0, lat);
    tests++;
    if ({lat == 4, bus.RESULT, bus.BORROW_OUT, bus.ZERO}
        !== {1'b1, 16'h0002, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL abort_new got lat%0d %h/%b/%b want 4 0002/0/0",
        lat, bus.RESULT, bus.BORROW_OUT, bus.ZERO);
    end
    finish_op();
  endtask

  task automatic test_abort_edges;
    int lat;
    bus.OP_A        = 16'h0009;
    bus.OP_B        = 16'h0001;
    bus.START_VALID = 1'b1;
    bus.ABORT       = 1'b1;
    tick();
    bus.START_VALID = 1'b0;
    bus.ABORT       = 1'b0;
    tests++;
    if ({bus.BUSY, bus.RESULT} !== {1'b0, 16'h0}) begin
      fails++;
      $display("FAIL abort_start got %b %h want 0 0000",
        bus.BUSY, bus.RESULT);
    end
    run_op(16'h0009, 16'h0001, 1'b0, lat);
    bus.ABORT = 1'b1;
    tick();
    bus.ABORT = 1'b0;
    tests++;
    if ({bus.BUSY, bus.RES_VALID, bus.RESULT}
        !== {2'b00, 16'h0}) begin
      fails++;
      $display("FAIL abort_done got %b%b %h want 00 0000",
        bus.BUSY, bus.RES_VALID, bus.RESULT);
    end
  endtask

  task automatic test_reset_mid;
    bus.OP_A        = 16'h1234;
    bus.OP_B        = 16'h0235;
    bus.BORROW_IN   = 1'b0;
    bus.START_VALID = 1'b1;
    tick();
    bus.START_VALID = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.RES_VALID, bus.BUSY, bus.ZERO,
         bus.BORROW_OUT, bus.RESULT} !== 20'h0) begin
      fails++;
      $display("FAIL rst_mid got %h want 0",
        {bus.RES_VALID, bus.BUSY, bus.ZERO,
         bus.BORROW_OUT, bus.RESULT});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++;
    if ({bus.START_READY, bus.BUSY, bus.RESULT}
        !== {2'b10, 16'h0}) begin
      fails++;
      $display("FAIL rst_rel got %b%b %h want 10 0000",
        bus.START_READY, bus.BUSY, bus.RESULT);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    run_op(16'h8000, 16'h7FFF, 1'b0, lat);
    tests++;
    if ({lat == 4, bus.RESULT, bus.BORROW_OUT, bus.ZERO}
        !== {1'b1, 16'h0001, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL b2b_0 got lat%0d %h/%b/%b want 4 0001/0/0",
        lat, bus.RESULT, bus.BORROW_OUT, bus.ZERO);
    end
    finish_op();
    run_op(16'h1000, 16'h2000, 1'b1, lat);
    tests++;
    if ({lat == 4, bus.RESULT, bus.BORROW_OUT, bus.ZERO}
        !== {1'b1, 16'hEFFF, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL b2b_1 got lat%0d %h/%b/%b want 4 efff/1/0",
        lat, bus.RESULT, bus.BORROW_OUT, bus.ZERO);
    end
    finish_op();
    run_op(16'hFFFF, 16'hFFFF, 1'b1, lat);
    tests++;
    if ({lat == 4, bus.RESULT, bus.BORROW_OUT, bus.ZERO}
        !== {1'b1, 16'hFFFF, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL b2b_2 got lat%0d %h/%b/%b want 4 ffff/1/0",
        lat, bus.RESULT, bus.BORROW_OUT, bus.ZERO);
    end
    finish_op();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_zero();
    test_hold();
    test_abort();
    test_abort_edges();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
